// File: rtl/uitpg_pkg.sv
// -----------------------------------------------------------------------------
// uitpg_pkg
// Shared definitions for the second-generation test pattern generator:
//   - mode encodings for the 16 selectable patterns
//   - colour-bar table as 3-bit {R,G,B} masks (expanded to CW bits in the top)
//   - fixed sync/data latency of the generator
// -----------------------------------------------------------------------------
package uitpg_pkg;

    // Sync, DE and pixel data all leave the generator this many clocks late.
    localparam int LAT = 2;

    localparam logic [3:0] MODE_BLACK       = 4'd0;
    localparam logic [3:0] MODE_WHITE       = 4'd1;
    localparam logic [3:0] MODE_RED         = 4'd2;
    localparam logic [3:0] MODE_GREEN       = 4'd3;
    localparam logic [3:0] MODE_BLUE        = 4'd4;
    localparam logic [3:0] MODE_GRID        = 4'd5;
    localparam logic [3:0] MODE_GREY_HRAMP  = 4'd6;
    localparam logic [3:0] MODE_GREY_VRAMP  = 4'd7;
    localparam logic [3:0] MODE_RED_VRAMP   = 4'd8;
    localparam logic [3:0] MODE_GREEN_HRAMP = 4'd9;
    localparam logic [3:0] MODE_BLUE_HRAMP  = 4'd10;
    localparam logic [3:0] MODE_BARS        = 4'd11;
    localparam logic [3:0] MODE_SCROLL_GRID = 4'd12;
    localparam logic [3:0] MODE_FLICK_GRID  = 4'd13;
    localparam logic [3:0] MODE_DIAG_RAMP   = 4'd14;
    localparam logic [3:0] MODE_BORDER      = 4'd15;

    // Last bar index; pixels beyond the eighth bar width stay here.
    localparam logic [2:0] BAR_LAST = 3'd7;

    // Bar colour as {R,G,B} on/off mask: white, yellow, cyan, green,
    // magenta, red, blue, black.
    function automatic logic [2:0] bar_rgb(input logic [2:0] idx);
        logic [2:0] rgb;
        case (idx)
            3'd0:    rgb = 3'b111;
            3'd1:    rgb = 3'b110;
            3'd2:    rgb = 3'b011;
            3'd3:    rgb = 3'b010;
            3'd4:    rgb = 3'b101;
            3'd5:    rgb = 3'b100;
            3'd6:    rgb = 3'b001;
            3'd7:    rgb = 3'b000;
            default: rgb = 3'b000;
        endcase
        return rgb;
    endfunction

endpackage

// File: rtl/uitpg_timing.sv
// -----------------------------------------------------------------------------
// uitpg_timing
// Raster position tracking for the pattern generator. All outputs are
// registered and describe the pixel that entered one clock earlier, so they
// line up with the first stage of the sync delay line in the top.
// Ports:
//   clk, rstn         pixel clock, synchronous active-low reset
//   vs, de            vertical sync (active-high) and active video in
//   mode_sel, auto_en manual pattern select / auto-cycle enable
//   h_cnt, v_cnt      pixel-in-line and active-line counters
//   line_w, frame_h   measured active width / height (0 until measured)
//   frame_cnt         8-bit frame counter (VS rising edges)
//   mode              pattern mode for the current frame
//   bar_idx           colour bar index of the current pixel
// AUTO_DIV_LOG2 must be in 1..8 (it selects low bits of frame_cnt).
// -----------------------------------------------------------------------------
module uitpg_timing
    import uitpg_pkg::*;
#(
    parameter int CNT_W         = 12,
    parameter int AUTO_DIV_LOG2 = 3
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             vs,
    input  logic             de,
    input  logic [3:0]       mode_sel,
    input  logic             auto_en,
    output logic [CNT_W-1:0] h_cnt,
    output logic [CNT_W-1:0] v_cnt,
    output logic [CNT_W-1:0] line_w,
    output logic [CNT_W-1:0] frame_h,
    output logic [7:0]       frame_cnt,
    output logic [3:0]       mode,
    output logic [2:0]       bar_idx
);

    logic             vs_d_r;
    logic             de_d_r;
    logic [CNT_W-1:0] h_cnt_r;
    logic [CNT_W-1:0] v_cnt_r;
    logic [CNT_W-1:0] line_w_r;
    logic [CNT_W-1:0] frame_h_r;
    logic [CNT_W-1:0] pib_r;        // pixel position inside the current bar
    logic [7:0]       frame_cnt_r;
    logic [3:0]       mode_r;
    logic [2:0]       bar_idx_r;

    logic             vs_rise_s;
    logic             de_rise_s;
    logic             de_fall_s;
    logic [CNT_W-1:0] bar_w_s;
    logic             bar_step_s;
    logic [CNT_W-1:0] h_nxt_s;
    logic [CNT_W-1:0] pib_nxt_s;
    logic [2:0]       bar_idx_nxt_s;

    assign vs_rise_s = vs & ~vs_d_r;
    assign de_rise_s = de & ~de_d_r;
    assign de_fall_s = ~de & de_d_r;

    // Bars are an eighth of the last measured line; 0 means nothing measured
    // yet and the whole line stays in bar 0.
    assign bar_w_s    = line_w_r >> 3'd3;
    assign bar_step_s = (bar_w_s != {CNT_W{1'b0}}) &&
                        (pib_r == (bar_w_s - 1'b1)) &&
                        (bar_idx_r != BAR_LAST);

    // Next horizontal / bar position for the pixel currently on the inputs.
    always_comb begin
        h_nxt_s       = h_cnt_r;
        pib_nxt_s     = pib_r;
        bar_idx_nxt_s = bar_idx_r;
        if (de_rise_s) begin
            h_nxt_s       = {CNT_W{1'b0}};
            pib_nxt_s     = {CNT_W{1'b0}};
            bar_idx_nxt_s = 3'd0;
        end else if (de) begin
            h_nxt_s = h_cnt_r + 1'b1;
            if (bar_step_s) begin
                bar_idx_nxt_s = bar_idx_r + 1'b1;
                pib_nxt_s     = {CNT_W{1'b0}};
            end else begin
                bar_idx_nxt_s = bar_idx_r;
                pib_nxt_s     = pib_r + 1'b1;
            end
        end else begin
            h_nxt_s       = h_cnt_r;
            pib_nxt_s     = pib_r;
            bar_idx_nxt_s = bar_idx_r;
        end
    end

    // Edge history, raster counters, measurements and frame-boundary mode.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            vs_d_r      <= 1'b0;
            de_d_r      <= 1'b0;
            h_cnt_r     <= {CNT_W{1'b0}};
            v_cnt_r     <= {CNT_W{1'b0}};
            line_w_r    <= {CNT_W{1'b0}};
            frame_h_r   <= {CNT_W{1'b0}};
            pib_r       <= {CNT_W{1'b0}};
            frame_cnt_r <= 8'd0;
            mode_r      <= 4'd0;
            bar_idx_r   <= 3'd0;
        end else begin
            vs_d_r    <= vs;
            de_d_r    <= de;
            h_cnt_r   <= h_nxt_s;
            pib_r     <= pib_nxt_s;
            bar_idx_r <= bar_idx_nxt_s;

            // h_cnt still holds the last active pixel of the line here.
            if (de_fall_s) begin
                line_w_r <= h_cnt_r + 1'b1;
            end

            if (vs_rise_s) begin
                frame_h_r   <= v_cnt_r;
                v_cnt_r     <= {CNT_W{1'b0}};
                frame_cnt_r <= frame_cnt_r + 1'b1;
                // Mode is only ever touched here, so a frame is never split.
                if (auto_en) begin
                    if (&frame_cnt_r[AUTO_DIV_LOG2-1:0]) begin
                        mode_r <= mode_r + 1'b1;
                    end
                end else begin
                    mode_r <= mode_sel;
                end
            end else if (de_fall_s) begin
                v_cnt_r <= v_cnt_r + 1'b1;
            end
        end
    end

    assign h_cnt     = h_cnt_r;
    assign v_cnt     = v_cnt_r;
    assign line_w    = line_w_r;
    assign frame_h   = frame_h_r;
    assign frame_cnt = frame_cnt_r;
    assign mode      = mode_r;
    assign bar_idx   = bar_idx_r;

endmodule

// File: rtl/uitpg_gen2.sv
// -----------------------------------------------------------------------------
// uitpg_gen2
// Second-generation video test pattern generator. Sits between the timing
// generator and the HDMI/LCD encoder; sync, DE and data leave together,
// LAT (=2) clocks after they enter.
// Ports:
//   I_tpg_clk, I_tpg_rstn        pixel clock, synchronous active-low reset
//   I_tpg_vs/hs/de               incoming sync and active-video strobes
//   I_mode, I_auto_en            manual pattern select / auto-cycle enable
//   O_tpg_vs/hs/de               sync and DE delayed by LAT
//   O_tpg_data                   {R,G,B}, CW bits each, 0 outside DE
//   O_mode                       pattern mode currently displayed
// -----------------------------------------------------------------------------
module uitpg_gen2
    import uitpg_pkg::*;
#(
    parameter int CW            = 8,
    parameter int GRID_LOG2     = 4,
    parameter int AUTO_DIV_LOG2 = 3,
    parameter int CNT_W         = 12
) (
    input  logic            I_tpg_clk,
    input  logic            I_tpg_rstn,
    input  logic            I_tpg_vs,
    input  logic            I_tpg_hs,
    input  logic            I_tpg_de,
    input  logic [3:0]      I_mode,
    input  logic            I_auto_en,
    output logic            O_tpg_vs,
    output logic            O_tpg_hs,
    output logic            O_tpg_de,
    output logic [3*CW-1:0] O_tpg_data,
    output logic [3:0]      O_mode
);

    logic [CNT_W-1:0] h_cnt_s;
    logic [CNT_W-1:0] v_cnt_s;
    logic [CNT_W-1:0] line_w_s;
    logic [CNT_W-1:0] frame_h_s;
    logic [7:0]       frame_cnt_s;
    logic [3:0]       mode_s;
    logic [2:0]       bar_idx_s;

    // First delay stage: runs in step with the registered counters.
    logic            vs_s1_r;
    logic            hs_s1_r;
    logic            de_s1_r;
    // Second (output) stage.
    logic            vs_out_r;
    logic            hs_out_r;
    logic            de_out_r;
    logic [3*CW-1:0] data_out_r;
    logic [3:0]      mode_out_r;

    uitpg_timing #(
        .CNT_W         (CNT_W),
        .AUTO_DIV_LOG2 (AUTO_DIV_LOG2)
    ) u_timing (
        .clk       (I_tpg_clk),
        .rstn      (I_tpg_rstn),
        .vs        (I_tpg_vs),
        .de        (I_tpg_de),
        .mode_sel  (I_mode),
        .auto_en   (I_auto_en),
        .h_cnt     (h_cnt_s),
        .v_cnt     (v_cnt_s),
        .line_w    (line_w_s),
        .frame_h   (frame_h_s),
        .frame_cnt (frame_cnt_s),
        .mode      (mode_s),
        .bar_idx   (bar_idx_s)
    );

    logic [CW-1:0]    full_s;
    logic [CW-1:0]    zero_s;
    logic [3*CW-1:0]  white_s;
    logic [3*CW-1:0]  black_s;
    logic [CW-1:0]    h_lo_s;
    logic [CW-1:0]    v_lo_s;
    logic [CNT_W-1:0] diag_sum_s;
    logic [CW-1:0]    diag_lo_s;
    logic [CNT_W-1:0] scroll_sum_s;
    logic             grid_s;
    logic             scroll_grid_s;
    logic             h_edge_s;
    logic             v_edge_s;
    logic [2:0]       bar_mask_s;
    logic [3*CW-1:0]  pix_s;

    assign full_s  = {CW{1'b1}};
    assign zero_s  = {CW{1'b0}};
    assign white_s = {full_s, full_s, full_s};
    assign black_s = {3*CW{1'b0}};

    assign h_lo_s       = h_cnt_s[CW-1:0];
    assign v_lo_s       = v_cnt_s[CW-1:0];
    assign diag_sum_s   = h_cnt_s + v_cnt_s;
    assign diag_lo_s    = diag_sum_s[CW-1:0];
    assign scroll_sum_s = h_cnt_s + CNT_W'(frame_cnt_s);

    assign grid_s        = (h_cnt_s[GRID_LOG2] == v_cnt_s[GRID_LOG2]);
    assign scroll_grid_s = (scroll_sum_s[GRID_LOG2] == v_cnt_s[GRID_LOG2]);

    // Far edges only count once a width/height has been measured.
    assign h_edge_s = (h_cnt_s == {CNT_W{1'b0}}) ||
                      ((line_w_s != {CNT_W{1'b0}}) && (h_cnt_s == (line_w_s - 1'b1)));
    assign v_edge_s = (v_cnt_s == {CNT_W{1'b0}}) ||
                      ((frame_h_s != {CNT_W{1'b0}}) && (v_cnt_s == (frame_h_s - 1'b1)));

    assign bar_mask_s = bar_rgb(bar_idx_s);

    // Pattern selection for the pixel in the first delay stage.
    always_comb begin
        pix_s = black_s;
        case (mode_s)
            MODE_BLACK:       pix_s = black_s;
            MODE_WHITE:       pix_s = white_s;
            MODE_RED:         pix_s = {full_s, zero_s, zero_s};
            MODE_GREEN:       pix_s = {zero_s, full_s, zero_s};
            MODE_BLUE:        pix_s = {zero_s, zero_s, full_s};
            MODE_GRID:        pix_s = grid_s ? white_s : black_s;
            MODE_GREY_HRAMP:  pix_s = {h_lo_s, h_lo_s, h_lo_s};
            MODE_GREY_VRAMP:  pix_s = {v_lo_s, v_lo_s, v_lo_s};
            MODE_RED_VRAMP:   pix_s = {v_lo_s, zero_s, zero_s};
            MODE_GREEN_HRAMP: pix_s = {zero_s, h_lo_s, zero_s};
            MODE_BLUE_HRAMP:  pix_s = {zero_s, zero_s, h_lo_s};
            MODE_BARS:        pix_s = {{CW{bar_mask_s[2]}}, {CW{bar_mask_s[1]}}, {CW{bar_mask_s[0]}}};
            MODE_SCROLL_GRID: pix_s = scroll_grid_s ? white_s : black_s;
            MODE_FLICK_GRID:  pix_s = (grid_s ^ frame_cnt_s[0]) ? white_s : black_s;
            MODE_DIAG_RAMP:   pix_s = {diag_lo_s, diag_lo_s, diag_lo_s};
            MODE_BORDER:      pix_s = (h_edge_s || v_edge_s) ? white_s : black_s;
            default:          pix_s = black_s;
        endcase
    end

    // Two-stage sync delay with the pattern registered into the second stage.
    always_ff @(posedge I_tpg_clk) begin
        if (!I_tpg_rstn) begin
            vs_s1_r    <= 1'b0;
            hs_s1_r    <= 1'b0;
            de_s1_r    <= 1'b0;
            vs_out_r   <= 1'b0;
            hs_out_r   <= 1'b0;
            de_out_r   <= 1'b0;
            data_out_r <= {3*CW{1'b0}};
            mode_out_r <= 4'd0;
        end else begin
            vs_s1_r    <= I_tpg_vs;
            hs_s1_r    <= I_tpg_hs;
            de_s1_r    <= I_tpg_de;
            vs_out_r   <= vs_s1_r;
            hs_out_r   <= hs_s1_r;
            de_out_r   <= de_s1_r;
            data_out_r <= de_s1_r ? pix_s : black_s;
            mode_out_r <= mode_s;
        end
    end

    assign O_tpg_vs   = vs_out_r;
    assign O_tpg_hs   = hs_out_r;
    assign O_tpg_de   = de_out_r;
    assign O_tpg_data = data_out_r;
    assign O_mode     = mode_out_r;

endmodule

// File: tb/tb_uitpg_gen2.sv
// -----------------------------------------------------------------------------
// tb_uitpg_gen2
// Scoreboard bench: the stimulus pushes the expected colour of every active
// pixel; a negedge monitor compares sync/DE against the inputs two clocks
// earlier and pops one expected pixel whenever O_tpg_de is high.
// -----------------------------------------------------------------------------
module tb_uitpg_gen2;

    localparam int CW = 8;

    logic            clk = 1'b0;
    logic            rstn;
    logic            vs;
    logic            hs;
    logic            de;
    logic [3:0]      mode_sel;
    logic            auto_en;
    logic            o_vs;
    logic            o_hs;
    logic            o_de;
    logic [3*CW-1:0] o_data;
    logic [3:0]      o_mode;

    always #5 clk = ~clk;

    uitpg_gen2 #(
        .CW            (CW),
        .GRID_LOG2     (4),
        .AUTO_DIV_LOG2 (1),
        .CNT_W         (12)
    ) dut (
        .I_tpg_clk  (clk),
        .I_tpg_rstn (rstn),
        .I_tpg_vs   (vs),
        .I_tpg_hs   (hs),
        .I_tpg_de   (de),
        .I_mode     (mode_sel),
        .I_auto_en  (auto_en),
        .O_tpg_vs   (o_vs),
        .O_tpg_hs   (o_hs),
        .O_tpg_de   (o_de),
        .O_tpg_data (o_data),
        .O_mode     (o_mode)
    );

    int          checks = 0;
    int          errors = 0;
    logic [23:0] exp_q[$];
    bit          mon_en = 1'b0;
    logic [2:0]  hist1 = 3'b000;
    logic [2:0]  hist2 = 3'b000;

    // Reference state: mode shown, frame counter, last measured width/height
    // and the active-line index inside the current frame.
    int m_mode = 0;
    int m_fc   = 0;
    int m_lw   = 0;
    int m_fh   = 0;
    int m_vcnt = 0;

    logic [23:0] bar_tab [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                 24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, req, $time);
        end
    endtask

    function automatic logic [23:0] exp_pix(input int md, input int x, input int y);
        logic [7:0] xb;
        logic [7:0] yb;
        logic [7:0] db;
        int         bw;
        int         idx;
        bit         g;
        bit         on_edge;
        xb = 8'(x);
        yb = 8'(y);
        db = 8'(x + y);
        g  = (((x >> 4) & 1) == ((y >> 4) & 1));
        case (md)
            0:  return 24'h000000;
            1:  return 24'hFFFFFF;
            2:  return 24'hFF0000;
            3:  return 24'h00FF00;
            4:  return 24'h0000FF;
            5:  return g ? 24'hFFFFFF : 24'h000000;
            6:  return {xb, xb, xb};
            7:  return {yb, yb, yb};
            8:  return {yb, 16'h0000};
            9:  return {8'h00, xb, 8'h00};
            10: return {16'h0000, xb};
            11: begin
                bw = m_lw / 8;
                if (bw == 0) idx = 0;
                else idx = x / bw;
                if (idx > 7) idx = 7;
                return bar_tab[idx];
            end
            12: return ((((x + m_fc) >> 4) & 1) == ((y >> 4) & 1)) ? 24'hFFFFFF : 24'h000000;
            13: return (g ^ (m_fc % 2 == 1)) ? 24'hFFFFFF : 24'h000000;
            14: return {db, db, db};
            15: begin
                on_edge = (x == 0) || (y == 0) || (m_lw != 0 && x == m_lw - 1) ||
                          (m_fh != 0 && y == m_fh - 1);
                return on_edge ? 24'hFFFFFF : 24'h000000;
            end
            default: return 24'h000000;
        endcase
    endfunction

    // Output monitor: latency check on sync/DE, scoreboard pop on DE.
    always @(negedge clk) begin
        logic [23:0] e;
        if (mon_en) begin
            chk("sync_delay", {29'd0, o_vs, o_hs, o_de}, {29'd0, hist2});
            if (o_de === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL pixel_underflow: got pixel %h, expected none queued", o_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("pixel", {8'd0, o_data}, {8'd0, e});
                end
            end else begin
                chk("blank_data", {8'd0, o_data}, 32'd0);
            end
        end
        hist2 = hist1;
        hist1 = {vs, hs, de};
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic hblank();
        de = 1'b0;
        cyc(); cyc();
        hs = 1'b1;
        cyc(); cyc();
        hs = 1'b0;
        cyc(); cyc();
    endtask

    task automatic line(input int w);
        for (int x = 0; x < w; x++) begin
            de = 1'b1;
            exp_q.push_back(exp_pix(m_mode, x, m_vcnt));
            cyc();
        end
        hblank();
        m_lw = w;
        m_vcnt++;
    endtask

    task automatic vsync();
        vs     = 1'b1;
        m_fh   = m_vcnt;
        m_vcnt = 0;
        if (auto_en) begin
            if (m_fc % 2 == 1) m_mode = (m_mode + 1) % 16;
        end else begin
            m_mode = int'(mode_sel);
        end
        m_fc = (m_fc + 1) % 256;
        cyc(); cyc();
        vs = 1'b0;
        cyc(); cyc(); cyc();
    endtask

    // One frame; the manual select changes after the first line so the
    // frame itself must not react to it.
    task automatic frame(input int w, input int h, input int nxt);
        line(w);
        mode_sel = 4'(nxt);
        chk("mode_frame_start", {28'd0, o_mode}, 32'(m_mode));
        for (int y = 1; y < h; y++) line(w);
        chk("mode_frame_end", {28'd0, o_mode}, 32'(m_mode));
        vsync();
    endtask

    // A line with a one-cycle reset pulse at pixel 'at'.
    task automatic reset_line(input int w, input int at);
        mon_en = 1'b0;
        for (int x = 0; x < w; x++) begin
            de   = 1'b1;
            rstn = (x == at) ? 1'b0 : 1'b1;
            cyc();
            if (x == at) begin
                chk("rst_mid_data", {8'd0, o_data}, 32'd0);
                chk("rst_mid_sync", {29'd0, o_vs, o_hs, o_de}, 32'd0);
                chk("rst_mid_mode", {28'd0, o_mode}, 32'd0);
            end
        end
        rstn = 1'b1;
        hblank();
        m_mode = 0;
        m_fc   = 0;
        m_fh   = 0;
        m_lw   = w - at - 1;
        m_vcnt = 1;
        mon_en = 1'b1;
    endtask

    initial begin
        rstn     = 1'b0;
        vs       = 1'b0;
        hs       = 1'b0;
        de       = 1'b0;
        mode_sel = 4'd1;
        auto_en  = 1'b0;
        repeat (3) cyc();
        chk("reset_data", {8'd0, o_data}, 32'd0);
        chk("reset_sync", {29'd0, o_vs, o_hs, o_de}, 32'd0);
        chk("reset_mode", {28'd0, o_mode}, 32'd0);
        rstn   = 1'b1;
        mon_en = 1'b1;

        // Manual white: first frame black, then white.
        frame(64, 16, 1);
        frame(64, 16, 1);
        frame(64, 16, 11);

        // Colour bars, including a 67-pixel line whose tail stays black.
        line(64);
        mode_sel = 4'd5;
        chk("bars_mode", {28'd0, o_mode}, 32'd11);
        line(64);
        line(64);
        line(67);
        line(64);
        vsync();

        // Grid, flicker grid on an odd then even frame, border, diagonal, scroll.
        frame(64, 32, 13);
        frame(64, 16, 13);
        frame(64, 16, 15);
        frame(64, 16, 15);
        frame(64, 16, 14);
        frame(64, 8, 12);
        frame(64, 8, 6);

        // Grey h-ramp with a reset pulse in the middle of the second line.
        line(64);
        reset_line(64, 20);
        line(64);
        chk("mode_after_rst", {28'd0, o_mode}, 32'd0);
        vsync();
        frame(64, 4, 6);

        // Clean reset, then auto-cycling: mode steps every two frames.
        rstn    = 1'b0;
        auto_en = 1'b1;
        cyc(); cyc();
        rstn   = 1'b1;
        m_mode = 0;
        m_fc   = 0;
        m_lw   = 0;
        m_fh   = 0;
        m_vcnt = 0;
        for (int k = 0; k < 34; k++) begin
            line(16);
            chk("auto_step", {28'd0, o_mode}, 32'((k / 2) % 16));
            line(16);
            chk("auto_hold", {28'd0, o_mode}, 32'((k / 2) % 16));
            vsync();
        end

        repeat (4) cyc();
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
